// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers and fixed-latency timing.
// The result is computed combinationally from the latched operands and is committed only on the final busy cycle.
module e_mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic             rd_sel,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [2*WIDTH-1:0] prod_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   uq_s;
  logic [WIDTH-1:0]   ur_s;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               commit_s;

  // Result datapath; signed divide works on magnitudes so MIN / -1 wraps to MIN naturally.
  always_comb begin
    prod_s   = {(2*WIDTH){1'b0}};
    neg_a_s  = 1'b0;
    neg_b_s  = 1'b0;
    mag_a_s  = a_r;
    mag_b_s  = b_r;
    uq_s     = W_ZERO;
    ur_s     = W_ZERO;
    q_s      = W_ZERO;
    r_s      = W_ZERO;
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    commit_s = 1'b0;

    if (op_r[0]) begin
      prod_s = {W_ZERO, a_r} * {W_ZERO, b_r};
    end else begin
      prod_s = $signed({{WIDTH{a_r[WIDTH-1]}}, a_r}) * $signed({{WIDTH{b_r[WIDTH-1]}}, b_r});
    end

    neg_a_s = ~op_r[0] & a_r[WIDTH-1];
    neg_b_s = ~op_r[0] & b_r[WIDTH-1];
    mag_a_s = neg_a_s ? (W_ZERO - a_r) : a_r;
    mag_b_s = neg_b_s ? (W_ZERO - b_r) : b_r;

    if (b_r != W_ZERO) begin
      uq_s = mag_a_s / mag_b_s;
      ur_s = mag_a_s % mag_b_s;
    end else begin
      uq_s = W_ZERO;
      ur_s = W_ZERO;
    end

    q_s = (neg_a_s ^ neg_b_s) ? (W_ZERO - uq_s) : uq_s;
    r_s = neg_a_s ? (W_ZERO - ur_s) : ur_s;

    if (op_r[1]) begin
      res_hi_s = r_s;
      res_lo_s = q_s;
      commit_s = (b_r != W_ZERO);
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
      commit_s = 1'b1;
    end
  end

  // Sequencer and HI/LO state: idle accepts start or MT writes, run counts down and commits on the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= CNT_ZERO;
      busy_r <= 1'b0;
      op_r   <= 2'b00;
      a_r    <= W_ZERO;
      b_r    <= W_ZERO;
      hi_r   <= W_ZERO;
      lo_r   <= W_ZERO;
    end else if (cnt_r == CNT_ZERO) begin
      if (start) begin
        op_r   <= md_op;
        a_r    <= a;
        b_r    <= b;
        cnt_r  <= md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        busy_r <= 1'b1;
      end else begin
        if (wr_hi) begin
          hi_r <= a;
        end
        if (wr_lo) begin
          lo_r <= a;
        end
      end
    end else begin
      cnt_r <= cnt_r - CNT_ONE;
      if (cnt_r == CNT_ONE) begin
        busy_r <= 1'b0;
        if (commit_s) begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
      end
    end
  end

  assign busy      = busy_r;
  assign stall_req = start | busy_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign rd_data   = rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized operations against a 64-bit arithmetic model.
module tb_e_mdu;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   md_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic         rd_sel;
  logic         busy;
  logic         stall_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd_data;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  e_mdu #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .rd_sel(rd_sel), .busy(busy),
    .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural meaning of each op, using 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, p;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'd0: begin p = sx * sy; {exp_hi, exp_lo} = p; end
      2'd1: begin up = 64'(x) * 64'(y); {exp_hi, exp_lo} = up; end
      2'd2: if (y != 0) begin exp_lo = 32'(sx / sy); exp_hi = 32'(sx % sy); end
      default: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
    endcase
  endfunction

  // Issue one op from idle and count busy cycles (bounded); leaves us in the first idle cycle.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int cycles);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; md_op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_req); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mult();
    int c;
    launch(2'd0, 32'hFFFFFFFE, 32'h3, c);
    vectors++; if (c != ML) begin miscompares++; $display("FAIL mult_busy got %0d want %0d", c, ML); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, c);
    vectors++; if (c != ML) begin miscompares++; $display("FAIL multu_busy got %0d want %0d", c, ML); end
    vectors++; if (hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int c;
    launch(2'd2, 32'hFFFFFFF9, 32'h2, c);
    vectors++; if (c != DL) begin miscompares++; $display("FAIL div_busy got %0d want %0d", c, DL); end
    vectors++; if (lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi got %h want ffffffff", hi); end
    launch(2'd3, 32'hFFFFFFF9, 32'h2, c);
    vectors++; if (lo !== 32'h7FFFFFFC) begin miscompares++; $display("FAIL divu_lo got %h want 7ffffffc", lo); end
    vectors++; if (hi !== 32'h00000001) begin miscompares++; $display("FAIL divu_hi got %h want 00000001", hi); end
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF, c);
    vectors++; if (lo !== 32'h80000000) begin miscompares++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    vectors++; if (hi !== 32'h00000000) begin miscompares++; $display("FAIL divovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_mt_mf();
    int c;
    @(negedge clk); wr_hi = 1'b1; a = 32'h12345678;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; a = 32'hABCDEF01;
    vectors++; if (hi !== 32'h12345678) begin miscompares++; $display("FAIL mthi_next got %h want 12345678", hi); end
    @(negedge clk); wr_lo = 1'b0;
    rd_sel = 1'b1; #1;
    vectors++; if (rd_data !== 32'h12345678) begin miscompares++; $display("FAIL mfhi got %h want 12345678", rd_data); end
    rd_sel = 1'b0; #1;
    vectors++; if (rd_data !== 32'hABCDEF01) begin miscompares++; $display("FAIL mflo got %h want abcdef01", rd_data); end
    launch(2'd2, 32'h00000064, 32'h0, c);
    vectors++; if (c != DL) begin miscompares++; $display("FAIL divzero_busy got %0d want %0d", c, DL); end
    vectors++; if (hi !== 32'h12345678 || lo !== 32'hABCDEF01) begin
      miscompares++; $display("FAIL divzero_keep got %h/%h want 12345678/abcdef01", hi, lo); end
    // start with MT writes in the same cycle: writes are dropped; b=0 keeps HI/LO so a leak would show
    @(negedge clk); start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; md_op = 2'd3; a = 32'h55555555; b = 32'h0;
    @(negedge clk); start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (DL + 1) @(negedge clk);
    vectors++; if (hi !== 32'h12345678 || lo !== 32'hABCDEF01) begin
      miscompares++; $display("FAIL start_wins got %h/%h want 12345678/abcdef01", hi, lo); end
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; a = 32'h0BADF00D;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
    vectors++; if (hi !== 32'h0BADF00D || lo !== 32'h0BADF00D) begin
      miscompares++; $display("FAIL mt_both got %h/%h want 0badf00d/0badf00d", hi, lo); end
  endtask

  task automatic test_busy_ignore();
    @(negedge clk); start = 1'b1; md_op = 2'd0; a = 32'h7; b = 32'h9; #1;
    vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL ign_stall_start got %b want 1", stall_req); end
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < ML; i++) begin
      vectors++; if (busy !== 1'b1 || stall_req !== 1'b1) begin
        miscompares++; $display("FAIL ign_busy_cycle%0d got busy=%b stall=%b want 1/1", i + 1, busy, stall_req); end
      wr_hi = (i == 1); start = (i == 2); md_op = 2'd2;
      a = (i == 1) ? 32'hDEAD0000 : 32'h00000100; b = 32'h3;
      @(negedge clk);
    end
    start = 1'b0; wr_hi = 1'b0;
    vectors++; if (busy !== 1'b0 || stall_req !== 1'b0) begin
      miscompares++; $display("FAIL ign_end got busy=%b stall=%b want 0/0", busy, stall_req); end
    vectors++; if (hi !== 32'h0 || lo !== 32'd63) begin
      miscompares++; $display("FAIL ign_result got %h/%h want 00000000/0000003f", hi, lo); end
    repeat (DL + 2) @(negedge clk);
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd63) begin
      miscompares++; $display("FAIL ign_no_relaunch got busy=%b %h/%h want 0 00000000/0000003f", busy, hi, lo); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk); start = 1'b1; md_op = 2'd2; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++; $display("FAIL abort_state got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
    repeat (DL + 2) @(negedge clk);
    vectors++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++; $display("FAIL abort_no_commit got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_random();
    int c;
    logic [1:0]   op;
    logic [W-1:0] x, y;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      model(op, x, y);
      launch(op, x, y, c);
      vectors++; if (c != (op[1] ? DL : ML)) begin
        miscompares++; $display("FAIL rnd%0d_busy op=%0d got %0d want %0d", n, op, c, op[1] ? DL : ML); end
      vectors++; if (hi !== exp_hi || lo !== exp_lo) begin
        miscompares++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got %h/%h want %h/%h", n, op, x, y, hi, lo, exp_hi, exp_lo); end
      rd_sel = 1'($urandom_range(0, 1)); #1;
      vectors++; if (rd_data !== (rd_sel ? exp_hi : exp_lo)) begin
        miscompares++; $display("FAIL rnd%0d_rd sel=%b got %h want %h", n, rd_sel, rd_data, rd_sel ? exp_hi : exp_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Parametrised multiply/divide unit for the E stage of the five-stage pipeline, with HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed, configurable number of cycles, plus MTHI/MTLO writes and MFHI/MFLO reads.
- Exposes busy so the hazard unit stalls D-stage multiply/divide instructions.
- Results commit to HI/LO only when an operation completes, so a stall/flush never exposes partial state.

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_LAT, 5, busy cycles for MULT/MULTU (>=1).
DIV_LAT, 10, busy cycles for DIV/DIVU (>=1).
CNT_W, 8, counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  launch the operation selected by md_op this cycle.
md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
a  in  WIDTH  rs operand (forwarded E value).
b  in  WIDTH  rt operand (forwarded E value).
wr_hi  in  1  MTHI: write a into HI.
wr_lo  in  1  MTLO: write a into LO.
rd_sel  in  1  0 selects LO, 1 selects HI on rd_data.
busy  out  1  operation in flight.
stall_req  out  1  start | busy, for the hazard unit.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
rd_data  out  WIDTH  rd_sel ? hi : lo (MFHI/MFLO value, combinational).

Behaviour:
- Reset: hi=0, lo=0, busy=0, counter=0, latched operands/op cleared. A reset mid-operation aborts the operation; HI/LO return to 0 and are never written.
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt != 0).
- IDLE with start=1 at edge T:
  - Latch a, b, md_op.
  - Load cnt with MULT_LAT (md_op[1]=0) or DIV_LAT (md_op[1]=1).
  - busy is high from the cycle after T for exactly LAT cycles.
- RUN: cnt decrements each edge. At the edge where cnt goes 1->0:
  - HI/LO take the result.
  - busy falls in the same edge.
  - New hi/lo are visible in the first cycle busy=0.
- Arithmetic, on latched operands:
  - MULT: {hi,lo} = signed a * signed b, 2*WIDTH-bit product.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- DIV with a = most-negative value, b = -1: lo = most-negative value, hi = 0 (wrap, no trap).
- Divide by zero (b==0): the operation still occupies DIV_LAT cycles; hi/lo are left unchanged.
- start while busy: ignored. The hazard unit guarantees this does not happen; the bench checks that no state is corrupted if it does.
- wr_hi/wr_lo while busy: ignored.
- wr_hi/wr_lo in IDLE: the register updates at the next edge.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins, the write is dropped.
- wr_hi and wr_lo together: both written with a.
- rd_data is purely combinational from current hi/lo; no bypass of in-flight results.
- stall_req is combinational (start | busy). D-stage MULT/DIV/MT/MF instructions stall while it is high.
- Internal implementation (shift-add, iterative, or single-cycle compute plus delay) is free; only the cycle timing above is visible.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
- MTHI a=0x12345678, next cycle MTLO a=0xABCDEF01 -> rd_sel=1 gives 0x12345678, rd_sel=0 gives 0xABCDEF01. Then DIV b=0 -> busy 10 cycles, hi/lo unchanged.
- Start MULT, pulse wr_hi and a second start during busy -> both ignored; final hi/lo equal the first MULT result; stall_req high from the start cycle through the last busy cycle.
- Start DIV, assert reset on busy cycle 4 -> next cycle busy=0, hi=lo=0; no later commit.
